duck_flight_ctrl: RTL and testbench
===================================

# duck_flight_ctrl

Consumes the 4-bit LFSR value from the random-number stage and turns it into one duck's flight: a random spawn column and heading, per-frame diagonal motion with wall bounces and periodic random re-heading, then either an escape off the top of the screen or a hit, stun and fall. Sits between the randomizer and the VGA sprite renderer/score logic. All motion advances only on the frame tick.

## Interface
- X_MIN, 16, left flight bound (pixels)
- X_MAX, 592, right flight bound
- GROUND_Y, 400, spawn and landing row
- TOP_Y, 16, escape row; must be >= SPEED
- SPEED, 2, pixels per frame tick, both axes, while flying
- FALL_SPEED, 4, pixels per frame tick while falling
- STUN_FRAMES, 30, frame ticks frozen after a hit
- clk0  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- random_bits  in  4  current randomizer value
- spawn_req  in  1  request a new duck; level, sampled in IDLE only
- hit  in  1  shot registered on duck; sampled in FLY only
- duck_x  out  10  sprite left edge
- duck_y  out  10  sprite top edge
- duck_dir_x  out  1  1 = moving right, 0 = left
- duck_active  out  1  high in FLY, STUN, FALL
- duck_falling  out  1  high in FALL
- escaped  out  1  one-cycle pulse: duck left the top
- shot_down  out  1  one-cycle pulse: duck reached ground after a hit
- state  out  2  IDLE=0, FLY=1, STUN=2, FALL=3

## Operation
- IDLE: spawn_req high at an edge loads x = {random_bits[3:1], 6'b0} + 32 (32..480, step 64), duck_dir_x = random_bits[0], y = GROUND_Y, redirect counter = 0 → FLY. frame_tick is not required.
- FLY, on frame_tick:
  - y: if y − SPEED <= TOP_Y, set y = TOP_Y, pulse escaped → IDLE; else y −= SPEED.
  - x, moving right: if x + SPEED >= X_MAX, set x = X_MAX and dir = 0; else x += SPEED.
  - x, moving left: if x <= X_MIN + SPEED, set x = X_MIN and dir = 1; else x −= SPEED.
  - Redirect: a 5-bit counter increments per tick. On the tick where it wraps from 31 to 0, dir = random_bits[0], unless a wall bounce happens on that tick (bounce wins).
- FLY, hit high at any edge (tick or not) → STUN. Position is frozen. Stun counter = 0.
- STUN: counts frame ticks. On the STUN_FRAMES-th tick → FALL, with no position change on that tick.
- FALL, on frame_tick: x is frozen. If y + FALL_SPEED >= GROUND_Y, set y = GROUND_Y, pulse shot_down → IDLE; else y += FALL_SPEED.
- Precedence:
  - hit and an escaping tick on the same edge: hit wins, no escaped pulse.
  - hit outside FLY: ignored.
  - spawn_req outside IDLE: ignored.
- Arithmetic is unsigned 10-bit. The parameter constraints guarantee no wrap.

## Timing
- Reset values: duck_x = 0, duck_y = GROUND_Y, duck_dir_x = 0, duck_active = 0, duck_falling = 0, escaped = 0, shot_down = 0, state = IDLE. All internal counters are 0.
- rst asserted mid-flight forces IDLE immediately (asynchronous). No pulse is emitted.
- Spawn latency: outputs show the new duck one edge after spawn_req is sampled.
- Movement updates land on the edge where frame_tick = 1. Outputs are registered.
- escaped and shot_down are registered and high for exactly the one cycle after the transition edge, coincident with state = IDLE.
- A spawn_req held high re-spawns on the first edge in IDLE, i.e. the cycle after the pulse.

## Test plan
- Spawn: random_bits = 4'b1011, spawn_req pulse → next cycle duck_x = 352, duck_y = 400, duck_dir_x = 1, state = FLY, duck_active = 1.
- Escape: spawn and hold random_bits = 4'b1011, then 192 frame ticks → escaped pulses once after tick 192; duck_y = 16, state = IDLE. After tick 191, duck_y = 18.
- Wall bounce: random_bits held 4'b1111, spawn at x = 480 → after tick 55 x = 590; tick 56 gives x = 592, dir = 0; tick 57 gives x = 590.
- Hit/fall: hit asserted when y = 300 → position frozen for 30 ticks; duck_falling rises after tick 30; 25 further ticks → y = 400, one shot_down pulse, IDLE.
- Hit on the same edge as an escaping tick → STUN, no escaped pulse. hit in IDLE and spawn_req in FLY → no effect.
- Async reset mid-FALL → outputs at reset values before the next clk0 edge. No shot_down pulse.

Source files
------------

// File: rtl/duck_flight_if.sv
// Bundle of control inputs and sprite/status outputs between the
// randomizer/game logic and the duck flight controller.
interface duck_flight_if;
    logic       frame_tick;
    logic [3:0] random_bits;
    logic       spawn_req;
    logic       hit;
    logic [9:0] duck_x;
    logic [9:0] duck_y;
    logic       duck_dir_x;
    logic       duck_active;
    logic       duck_falling;
    logic       escaped;
    logic       shot_down;
    logic [1:0] state;

    modport master (
        output frame_tick, random_bits, spawn_req, hit,
        input  duck_x, duck_y, duck_dir_x, duck_active, duck_falling,
               escaped, shot_down, state
    );

    modport slave (
        input  frame_tick, random_bits, spawn_req, hit,
        output duck_x, duck_y, duck_dir_x, duck_active, duck_falling,
               escaped, shot_down, state
    );
endinterface

// File: rtl/duck_flight_ctrl.sv
// One duck's life: random spawn, diagonal flight with wall bounces and
// periodic random re-heading, then escape off the top or hit/stun/fall.
// All motion advances on frame_tick only.
module duck_flight_ctrl #(
    parameter logic [9:0] X_MIN       = 10'd16,
    parameter logic [9:0] X_MAX       = 10'd592,
    parameter logic [9:0] GROUND_Y    = 10'd400,
    parameter logic [9:0] TOP_Y       = 10'd16,
    parameter logic [9:0] SPEED       = 10'd2,
    parameter logic [9:0] FALL_SPEED  = 10'd4,
    parameter int         STUN_FRAMES = 30
) (
    input logic          clk0,
    input logic          rst,
    duck_flight_if.slave bus
);

    localparam int         STUN_W     = $clog2(STUN_FRAMES + 1);
    localparam logic [9:0] SPAWN_BASE = 10'd32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        STUN = 2'd2,
        FALL = 2'd3
    } state_t;

    state_t            state_q, state_n;
    logic [9:0]        x_q, x_n;
    logic [9:0]        y_q, y_n;
    logic              dir_q, dir_n;
    logic [4:0]        redir_q, redir_n;
    logic [STUN_W-1:0] stun_q, stun_n;
    logic              esc_q, esc_n;
    logic              sd_q, sd_n;
    logic              bounce;

    // State, position and pulse registers; reset parks the duck on the ground.
    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= GROUND_Y;
            dir_q   <= 1'b0;
            redir_q <= '0;
            stun_q  <= '0;
            esc_q   <= 1'b0;
            sd_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            x_q     <= x_n;
            y_q     <= y_n;
            dir_q   <= dir_n;
            redir_q <= redir_n;
            stun_q  <= stun_n;
            esc_q   <= esc_n;
            sd_q    <= sd_n;
        end
    end

    // Next-state and motion logic; hit in FLY overrides any movement that edge.
    always_comb begin
        state_n = state_q;
        x_n     = x_q;
        y_n     = y_q;
        dir_n   = dir_q;
        redir_n = redir_q;
        stun_n  = stun_q;
        esc_n   = 1'b0;
        sd_n    = 1'b0;
        bounce  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.spawn_req) begin
                    x_n     = 10'({bus.random_bits[3:1], 6'b0}) + SPAWN_BASE;
                    dir_n   = bus.random_bits[0];
                    y_n     = GROUND_Y;
                    redir_n = '0;
                    state_n = FLY;
                end
            end
            FLY: begin
                if (bus.hit) begin
                    stun_n  = '0;
                    state_n = STUN;
                end else if (bus.frame_tick) begin
                    redir_n = redir_q + 5'd1;
                    if (dir_q) begin
                        if (x_q + SPEED >= X_MAX) begin
                            x_n    = X_MAX;
                            dir_n  = 1'b0;
                            bounce = 1'b1;
                        end else begin
                            x_n = x_q + SPEED;
                        end
                    end else begin
                        if (x_q <= X_MIN + SPEED) begin
                            x_n    = X_MIN;
                            dir_n  = 1'b1;
                            bounce = 1'b1;
                        end else begin
                            x_n = x_q - SPEED;
                        end
                    end
                    if ((redir_q == 5'd31) && !bounce) begin
                        dir_n = bus.random_bits[0];
                    end
                    if (y_q - SPEED <= TOP_Y) begin
                        y_n     = TOP_Y;
                        esc_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        y_n = y_q - SPEED;
                    end
                end
            end
            STUN: begin
                if (bus.frame_tick) begin
                    if (stun_q == STUN_W'(STUN_FRAMES - 1)) begin
                        stun_n  = '0;
                        state_n = FALL;
                    end else begin
                        stun_n = stun_q + 1'b1;
                    end
                end
            end
            FALL: begin
                if (bus.frame_tick) begin
                    if (y_q + FALL_SPEED >= GROUND_Y) begin
                        y_n     = GROUND_Y;
                        sd_n    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        y_n = y_q + FALL_SPEED;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.duck_x       = x_q;
    assign bus.duck_y       = y_q;
    assign bus.duck_dir_x   = dir_q;
    assign bus.duck_active  = (state_q != IDLE);
    assign bus.duck_falling = (state_q == FALL);
    assign bus.escaped      = esc_q;
    assign bus.shot_down    = sd_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_duck_flight_ctrl.sv
// Testbench for duck_flight_ctrl: directed scenarios plus random stimulus,
// compared against a behavioural model through an expected-value queue.
module tb_duck_flight_ctrl;

    localparam int X_MIN = 16, X_MAX = 592, GROUND_Y = 400, TOP_Y = 16;
    localparam int SPEED = 2, FALL_SPEED = 4, STUN_FRAMES = 30;

    typedef struct {
        int x, y, dir, active, falling, esc, sd, st;
    } exp_t;

    logic clk0 = 1'b0;
    logic rst  = 1'b1;
    duck_flight_if dfi ();

    duck_flight_ctrl dut (
        .clk0 (clk0),
        .rst  (rst),
        .bus  (dfi.slave)
    );

    always #5 clk0 = ~clk0;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    int m_mode = 0, m_x = 0, m_y = GROUND_Y, m_dir = 0;
    int m_flyticks = 0, m_stunticks = 0, m_esc = 0, m_sd = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model of one clock edge, written from the flight rules.
    function automatic void modelStep(input logic r, input logic t, input logic [3:0] rb,
                                      input logic sp, input logic h);
        int bounced;
        m_esc = 0;
        m_sd  = 0;
        if (r) begin
            m_mode = 0; m_x = 0; m_y = GROUND_Y; m_dir = 0;
            m_flyticks = 0; m_stunticks = 0;
            return;
        end
        case (m_mode)
            0: if (sp) begin
                m_x = int'(rb[3:1]) * 64 + 32;
                m_dir = int'(rb[0]);
                m_y = GROUND_Y;
                m_flyticks = 0;
                m_mode = 1;
            end
            1: if (h) begin
                m_mode = 2;
                m_stunticks = 0;
            end else if (t) begin
                bounced = 0;
                m_flyticks++;
                if (m_dir == 1) begin
                    if (m_x + SPEED >= X_MAX) begin m_x = X_MAX; m_dir = 0; bounced = 1; end
                    else m_x = m_x + SPEED;
                end else begin
                    if (m_x <= X_MIN + SPEED) begin m_x = X_MIN; m_dir = 1; bounced = 1; end
                    else m_x = m_x - SPEED;
                end
                if ((m_flyticks % 32 == 0) && (bounced == 0)) m_dir = int'(rb[0]);
                if (m_y - SPEED <= TOP_Y) begin m_y = TOP_Y; m_esc = 1; m_mode = 0; end
                else m_y = m_y - SPEED;
            end
            2: if (t) begin
                m_stunticks++;
                if (m_stunticks == STUN_FRAMES) m_mode = 3;
            end
            default: if (t) begin
                if (m_y + FALL_SPEED >= GROUND_Y) begin m_y = GROUND_Y; m_sd = 1; m_mode = 0; end
                else m_y = m_y + FALL_SPEED;
            end
        endcase
    endfunction

    // Drive one cycle of inputs at the falling edge and queue the model's prediction.
    task automatic applyStimulus(input logic r, input logic t, input logic [3:0] rb,
                                 input logic sp, input logic h);
        exp_t e;
        @(negedge clk0);
        rst             = r;
        dfi.frame_tick  = t;
        dfi.random_bits = rb;
        dfi.spawn_req   = sp;
        dfi.hit         = h;
        modelStep(r, t, rb, sp, h);
        e.x = m_x; e.y = m_y; e.dir = m_dir;
        e.active = (m_mode != 0) ? 1 : 0;
        e.falling = (m_mode == 3) ? 1 : 0;
        e.esc = m_esc; e.sd = m_sd; e.st = m_mode;
        exp_q.push_back(e);
    endtask

    task automatic afterEdge();
        @(posedge clk0);
        #1;
    endtask

    task automatic runTicks(input int n, input logic [3:0] rb);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, rb, 1'b0, 1'b0);
    endtask

    task automatic runUntilIdle(input logic [3:0] rb);
        for (int i = 0; i < 2000 && m_mode != 0; i++) applyStimulus(1'b0, 1'b1, rb, 1'b0, 1'b0);
        afterEdge();
        checkOutput("reached_idle", int'(dfi.state), 0);
    endtask

    // Monitor: every edge with a pending prediction is compared field by field.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk0);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("sb_x",       int'(dfi.duck_x),       e.x);
                checkOutput("sb_y",       int'(dfi.duck_y),       e.y);
                checkOutput("sb_dir",     int'(dfi.duck_dir_x),   e.dir);
                checkOutput("sb_active",  int'(dfi.duck_active),  e.active);
                checkOutput("sb_falling", int'(dfi.duck_falling), e.falling);
                checkOutput("sb_escaped", int'(dfi.escaped),      e.esc);
                checkOutput("sb_shot",    int'(dfi.shot_down),    e.sd);
                checkOutput("sb_state",   int'(dfi.state),        e.st);
            end
        end
    end

    initial begin
        dfi.frame_tick  = 1'b0;
        dfi.random_bits = 4'd0;
        dfi.spawn_req   = 1'b0;
        dfi.hit         = 1'b0;

        // Reset values
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        afterEdge();
        checkOutput("rst_x", int'(dfi.duck_x), 0);
        checkOutput("rst_y", int'(dfi.duck_y), GROUND_Y);
        checkOutput("rst_state", int'(dfi.state), 0);
        checkOutput("rst_active", int'(dfi.duck_active), 0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Spawn and escape
        applyStimulus(1'b0, 1'b0, 4'b1011, 1'b1, 1'b0);
        afterEdge();
        checkOutput("spawn_x", int'(dfi.duck_x), 352);
        checkOutput("spawn_y", int'(dfi.duck_y), 400);
        checkOutput("spawn_dir", int'(dfi.duck_dir_x), 1);
        checkOutput("spawn_state", int'(dfi.state), 1);
        checkOutput("spawn_active", int'(dfi.duck_active), 1);
        runTicks(191, 4'b1011);
        afterEdge();
        checkOutput("esc_y_191", int'(dfi.duck_y), 18);
        checkOutput("esc_none_191", int'(dfi.escaped), 0);
        runTicks(1, 4'b1011);
        afterEdge();
        checkOutput("esc_pulse", int'(dfi.escaped), 1);
        checkOutput("esc_y", int'(dfi.duck_y), 16);
        checkOutput("esc_state", int'(dfi.state), 0);
        applyStimulus(1'b0, 1'b0, 4'b1011, 1'b0, 1'b0);
        afterEdge();
        checkOutput("esc_pulse_end", int'(dfi.escaped), 0);

        // Wall bounce
        applyStimulus(1'b0, 1'b0, 4'b1111, 1'b1, 1'b0);
        runTicks(55, 4'b1111);
        afterEdge();
        checkOutput("wall_x_55", int'(dfi.duck_x), 590);
        runTicks(1, 4'b1111);
        afterEdge();
        checkOutput("wall_x_56", int'(dfi.duck_x), 592);
        checkOutput("wall_dir_56", int'(dfi.duck_dir_x), 0);
        runTicks(1, 4'b1111);
        afterEdge();
        checkOutput("wall_x_57", int'(dfi.duck_x), 590);
        runUntilIdle(4'b1111);

        // Hit, stun and fall
        applyStimulus(1'b0, 1'b0, 4'b1011, 1'b1, 1'b0);
        runTicks(50, 4'b1011);
        applyStimulus(1'b0, 1'b0, 4'b1011, 1'b0, 1'b1);
        afterEdge();
        checkOutput("hit_state", int'(dfi.state), 2);
        checkOutput("hit_y", int'(dfi.duck_y), 300);
        runTicks(29, 4'b1011);
        afterEdge();
        checkOutput("stun_falling_29", int'(dfi.duck_falling), 0);
        runTicks(1, 4'b1011);
        afterEdge();
        checkOutput("stun_falling_30", int'(dfi.duck_falling), 1);
        checkOutput("stun_y_30", int'(dfi.duck_y), 300);
        runTicks(24, 4'b1011);
        afterEdge();
        checkOutput("fall_y_24", int'(dfi.duck_y), 396);
        runTicks(1, 4'b1011);
        afterEdge();
        checkOutput("fall_y_land", int'(dfi.duck_y), 400);
        checkOutput("fall_shot", int'(dfi.shot_down), 1);
        checkOutput("fall_state", int'(dfi.state), 0);

        // Hit on the escaping tick, then async reset mid-fall
        applyStimulus(1'b0, 1'b0, 4'b1011, 1'b1, 1'b0);
        runTicks(191, 4'b1011);
        applyStimulus(1'b0, 1'b1, 4'b1011, 1'b0, 1'b1);
        afterEdge();
        checkOutput("hitesc_state", int'(dfi.state), 2);
        checkOutput("hitesc_escaped", int'(dfi.escaped), 0);
        runTicks(33, 4'b1011);
        applyStimulus(1'b1, 1'b0, 4'b1011, 1'b0, 1'b0);
        #1;
        checkOutput("arst_state", int'(dfi.state), 0);
        checkOutput("arst_y", int'(dfi.duck_y), GROUND_Y);
        checkOutput("arst_x", int'(dfi.duck_x), 0);
        checkOutput("arst_falling", int'(dfi.duck_falling), 0);
        checkOutput("arst_shot", int'(dfi.shot_down), 0);
        applyStimulus(1'b0, 1'b0, 4'b1011, 1'b0, 1'b0);

        // hit in IDLE and spawn_req in FLY are ignored
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 4'b0101, 1'b0, 1'b1);
        afterEdge();
        checkOutput("idle_hit_state", int'(dfi.state), 0);
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 4'b1110, 1'b1, 1'b0);
        afterEdge();
        checkOutput("fly_spawn_x", int'(dfi.duck_x), 26);
        runUntilIdle(4'b0000);

        // Random stimulus
        for (int i = 0; i < 4000; i++) begin
            applyStimulus($urandom_range(0, 999) == 0, $urandom_range(0, 2) != 0,
                          4'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
        end

        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        afterEdge();
        #2;
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
